// File: rtl/bpm_stream_merger.sv
// Merges the CCW and CW BPM packet streams into one AXI stream.
// Each link buffers whole validated packets; a round-robin arbiter drains them.

module bpm_link_buf #(
  parameter int          PKT_SIZE_WORDS = 4,
  parameter int          FIFO_PKTS      = 2,
  parameter logic [15:0] MAGIC          = 16'hA5BE,
  localparam int         CW             = $clog2(FIFO_PKTS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic [31:0]   tdata,
  input  logic          tlast,
  input  logic          tvalid,
  input  logic          rd_en,
  output logic [32:0]   rd_word,
  output logic [CW-1:0] pkt_cnt,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   bad_cnt
);
  localparam int DEPTH = FIFO_PKTS * PKT_SIZE_WORDS;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(PKT_SIZE_WORDS + 1);

  typedef enum logic [1:0] {IN_HDR, IN_BODY, IN_SKIP} in_state_t;

  logic [32:0]   mem [DEPTH];
  in_state_t     in_st, in_st_n;
  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_eff;
  logic [IW-1:0] idx;
  logic          hdr_ok, ok_hdr, at_last, room, rd_last;
  logic          accept, wr_en, commit, rewind, bad, drop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign rd_word = mem[rd_ptr];
  assign rd_last = rd_en & rd_word[32];
  assign at_last = (idx == IW'(PKT_SIZE_WORDS - 1));
  assign ok_hdr  = (in_st == IN_HDR) ? (tdata[31:16] == MAGIC) : hdr_ok;
  // occ counts committed, unread words; a word read this cycle frees its slot now
  assign occ_eff = occ - OW'(rd_en);
  assign room    = (occ_eff <= OW'(DEPTH - PKT_SIZE_WORDS));

  always_comb begin
    in_st_n = in_st;
    accept  = 1'b0;
    wr_en   = 1'b0;
    commit  = 1'b0;
    rewind  = 1'b0;
    bad     = 1'b0;
    drop    = 1'b0;
    if (tvalid) begin
      case (in_st)
        IN_HDR: begin
          if (!enable) begin
            if (!tlast) in_st_n = IN_SKIP;
          end else if (!room) begin
            drop = 1'b1;
            if (!tlast) in_st_n = IN_SKIP;
          end else begin
            accept = 1'b1;
          end
        end
        IN_BODY: accept = 1'b1;
        default: if (tlast) in_st_n = IN_HDR;
      endcase
    end
    if (accept) begin
      if (tlast) begin
        in_st_n = IN_HDR;
        if (at_last && ok_hdr) begin
          wr_en  = 1'b1;
          commit = 1'b1;
        end else begin
          bad    = 1'b1;
          rewind = 1'b1;
        end
      end else if (at_last) begin
        // missing tlast: drop what we have and swallow beats up to the next tlast
        bad     = 1'b1;
        rewind  = 1'b1;
        in_st_n = IN_SKIP;
      end else begin
        wr_en   = 1'b1;
        in_st_n = IN_BODY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {tlast, tdata};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_st    <= IN_HDR;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      idx      <= '0;
      hdr_ok   <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      in_st <= in_st_n;
      if (accept) begin
        idx    <= (in_st_n == IN_BODY) ? idx + 1'b1 : '0;
        hdr_ok <= ok_hdr;
      end
      if (commit) begin
        wr_ptr  <= inc(wr_ptr);
        cmt_ptr <= inc(wr_ptr);
      end else if (rewind) begin
        wr_ptr <= cmt_ptr;
      end else if (wr_en) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= inc(rd_ptr);
      occ     <= occ_eff + (commit ? OW'(PKT_SIZE_WORDS) : '0);
      pkt_cnt <= pkt_cnt + CW'(commit) - CW'(rd_last);
      if (drop) drop_cnt <= sat(drop_cnt);
      if (bad)  bad_cnt  <= sat(bad_cnt);
    end
  end
endmodule

module bpm_stream_merger #(
  parameter int          PKT_SIZE_WORDS = 4,
  parameter int          FIFO_PKTS      = 2,
  parameter logic [15:0] MAGIC          = 16'hA5BE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] ccw_tdata,
  input  logic        ccw_tlast,
  input  logic        ccw_tvalid,
  input  logic [31:0] cw_tdata,
  input  logic        cw_tlast,
  input  logic        cw_tvalid,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic [15:0] ccw_drop_cnt,
  output logic [15:0] cw_drop_cnt,
  output logic [15:0] ccw_bad_cnt,
  output logic [15:0] cw_bad_cnt
);
  localparam int NL = 2;
  localparam int CW = $clog2(FIFO_PKTS + 1);

  typedef enum logic {IDLE, SEND} arb_state_t;

  // link index 0 = CCW, 1 = CW (matches m_tuser encoding)
  logic [NL-1:0][31:0]   s_tdata;
  logic [NL-1:0]         s_tlast, s_tvalid, rd_en, elig;
  logic [NL-1:0][32:0]   rd_word;
  logic [NL-1:0][CW-1:0] pkt_cnt;
  logic [NL-1:0][15:0]   drop_cnt, bad_cnt;

  arb_state_t state, state_n;
  logic       grant, grant_n, last_srv, last_n, ref_last, end_pkt;
  logic [32:0] cur;

  assign s_tdata  = {cw_tdata, ccw_tdata};
  assign s_tlast  = {cw_tlast, ccw_tlast};
  assign s_tvalid = {cw_tvalid, ccw_tvalid};

  for (genvar i = 0; i < NL; i++) begin : g_link
    bpm_link_buf #(
      .PKT_SIZE_WORDS(PKT_SIZE_WORDS),
      .FIFO_PKTS     (FIFO_PKTS),
      .MAGIC         (MAGIC)
    ) u_link (
      .clk     (clk),
      .resetn  (resetn),
      .enable  (enable),
      .tdata   (s_tdata[i]),
      .tlast   (s_tlast[i]),
      .tvalid  (s_tvalid[i]),
      .rd_en   (rd_en[i]),
      .rd_word (rd_word[i]),
      .pkt_cnt (pkt_cnt[i]),
      .drop_cnt(drop_cnt[i]),
      .bad_cnt (bad_cnt[i])
    );
  end

  assign cur     = rd_word[grant];
  assign end_pkt = (state == SEND) && m_tready && cur[32];

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    last_n   = last_srv;
    ref_last = last_srv;
    elig     = '0;
    rd_en    = '0;
    case (state)
      IDLE: begin
        elig[0] = (pkt_cnt[0] != '0);
        elig[1] = (pkt_cnt[1] != '0);
      end
      default: begin
        rd_en[grant] = m_tready;
        if (end_pkt) begin
          // the packet being finished is still counted, so its link needs two
          state_n       = IDLE;
          last_n        = grant;
          ref_last      = grant;
          elig[grant]   = (pkt_cnt[grant] > CW'(1));
          elig[~grant]  = (pkt_cnt[~grant] != '0);
        end
      end
    endcase
    if (elig != '0) begin
      state_n = SEND;
      grant_n = (&elig) ? ~ref_last : elig[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 1'b0;
      last_srv <= 1'b1;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      last_srv <= last_n;
    end
  end

  assign m_tvalid     = (state == SEND);
  assign m_tdata      = m_tvalid ? cur[31:0] : '0;
  assign m_tlast      = m_tvalid & cur[32];
  assign m_tuser      = m_tvalid & grant;
  assign ccw_drop_cnt = drop_cnt[0];
  assign cw_drop_cnt  = drop_cnt[1];
  assign ccw_bad_cnt  = bad_cnt[0];
  assign cw_bad_cnt   = bad_cnt[1];
endmodule

// File: tb/tb_bpm_stream_merger.sv
// Self-checking bench for bpm_stream_merger: packet table plus hand-written
// stall, arbitration and reset sequences, with a scoreboard on the output.

module tb_bpm_stream_merger;
  localparam int PKT = 4;

  logic        clk = 1'b0;
  logic        resetn, enable;
  logic [31:0] ccw_tdata, cw_tdata, m_tdata;
  logic        ccw_tlast, ccw_tvalid, cw_tlast, cw_tvalid;
  logic        m_tlast, m_tvalid, m_tready, m_tuser;
  logic [15:0] ccw_drop_cnt, cw_drop_cnt, ccw_bad_cnt, cw_bad_cnt;

  bpm_stream_merger dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .ccw_tdata(ccw_tdata), .ccw_tlast(ccw_tlast), .ccw_tvalid(ccw_tvalid),
    .cw_tdata(cw_tdata), .cw_tlast(cw_tlast), .cw_tvalid(cw_tvalid),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tuser(m_tuser),
    .ccw_drop_cnt(ccw_drop_cnt), .cw_drop_cnt(cw_drop_cnt),
    .ccw_bad_cnt(ccw_bad_cnt), .cw_bad_cnt(cw_bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          link;
    logic [31:0] hdr;
    int          n;
    int          tl;
    int          en_off;
    bit          out;
    int          ccw_bad;
    int          cw_bad;
  } vec_t;

  vec_t        tbl [9];
  logic [33:0] sb [$];
  int          checks = 0, errors = 0;
  int          beats, first_cyc, last_cyc, tl_cyc;
  bit          sb_off = 1'b0;

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input bit link, input logic [31:0] h, input int k);
    return (k == 0) ? h : {h[15:0], (link ? 8'hC1 : 8'hC0), 8'(k)};
  endfunction

  task automatic push(input bit link, input logic [31:0] h);
    for (int k = 0; k < PKT; k++) sb.push_back({link, (k == PKT - 1), word(link, h, k)});
  endtask

  task automatic monitor();
    logic [33:0] prev, cur, exp;
    bit stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {m_tuser, m_tlast, m_tdata};
      if (resetn && m_tvalid) begin
        if (stall_prev) chk("stall_hold", cur, prev);
        if (m_tready) begin
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (!sb_off) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_beat: got %0h expected no output", cur);
            end else begin
              exp = sb.pop_front();
              chk("out_beat", cur, exp);
            end
          end
        end
        stall_prev = !m_tready;
        prev = cur;
      end else begin
        stall_prev = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit dc, input bit dw, input logic [31:0] hc, input logic [31:0] hw,
                       input int n, input int tl, input int en_off, input bit pc, input bit pw);
    if (pc) push(1'b0, hc);
    if (pw) push(1'b1, hw);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      enable     = (en_off < 0) || (k < en_off);
      ccw_tvalid = dc; ccw_tdata = word(1'b0, hc, k); ccw_tlast = dc && (k == tl);
      cw_tvalid  = dw; cw_tdata  = word(1'b1, hw, k); cw_tlast  = dw && (k == tl);
      if (k == tl) tl_cyc = cyc;
    end
    @(posedge clk); #1;
    ccw_tvalid = 1'b0; ccw_tlast = 1'b0;
    cw_tvalid  = 1'b0; cw_tlast  = 1'b0;
    enable     = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", 34'(sb.size()), 34'd0);
    repeat (8) @(posedge clk);
  endtask

  task automatic chk_cnt(input int cb, input int wb, input int cd, input int wd);
    @(negedge clk);
    chk("ccw_bad_cnt", 34'(ccw_bad_cnt), 34'(cb));
    chk("cw_bad_cnt", 34'(cw_bad_cnt), 34'(wb));
    chk("ccw_drop_cnt", 34'(ccw_drop_cnt), 34'(cd));
    chk("cw_drop_cnt", 34'(cw_drop_cnt), 34'(wd));
  endtask

  initial begin
    int i;
    tbl[0] = '{1'b1, 32'hA5BE0002, 4, 3, -1, 1'b1, 0, 0};
    tbl[1] = '{1'b1, 32'h12348001, 4, 3, -1, 1'b0, 0, 1};
    tbl[2] = '{1'b1, 32'hA5BE0003, 3, 2, -1, 1'b0, 0, 2};
    tbl[3] = '{1'b1, 32'hA5BE0004, 6, 5, -1, 1'b0, 0, 3};
    tbl[4] = '{1'b0, 32'hA5BE0005, 4, 3,  0, 1'b0, 0, 3};
    tbl[5] = '{1'b0, 32'hA5BE0006, 2, 1, -1, 1'b0, 1, 3};
    tbl[6] = '{1'b0, 32'hA5BE0007, 4, 3, -1, 1'b1, 1, 3};
    tbl[7] = '{1'b0, 32'hA5BE0008, 4, 3,  1, 1'b1, 1, 3};
    tbl[8] = '{1'b1, 32'hA5BEFFFF, 4, 3, -1, 1'b1, 1, 3};

    resetn = 1'b0; enable = 1'b1; m_tready = 1'b1;
    ccw_tdata = '0; ccw_tlast = 1'b0; ccw_tvalid = 1'b0;
    cw_tdata  = '0; cw_tlast  = 1'b0; cw_tvalid  = 1'b0;
    beats = 0; first_cyc = -1; last_cyc = 0; tl_cyc = 0;
    fork
      monitor();
      begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 34'(m_tvalid), 34'd0);
    chk("rst_tdata", 34'(m_tdata), 34'd0);
    chk("rst_tlast", 34'(m_tlast), 34'd0);
    chk("rst_tuser", 34'(m_tuser), 34'd0);
    chk_cnt(0, 0, 0, 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // single CCW packet, latency from tlast beat to first output beat
    first_cyc = -1;
    drive(1'b1, 1'b0, 32'hA5BE8001, 32'h0, 4, 3, -1, 1'b1, 1'b0);
    wait_drain();
    chk("latency", 34'(first_cyc - tl_cyc), 34'd2);

    for (int r = 0; r < 9; r++) begin
      drive(!tbl[r].link, tbl[r].link, tbl[r].hdr, tbl[r].hdr, tbl[r].n, tbl[r].tl,
            tbl[r].en_off, tbl[r].out && !tbl[r].link, tbl[r].out && tbl[r].link);
      wait_drain();
      chk_cnt(tbl[r].ccw_bad, tbl[r].cw_bad, 0, 0);
    end

    // both links simultaneously; last served was CW so the first tie goes to CCW
    beats = 0; first_cyc = -1;
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b1, 32'hA5BE1000 + 32'(p), 32'hA5BE2000 + 32'(p), 4, 3, -1, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
    end
    wait_drain();
    chk("b2b_beats", 34'(beats), 34'd24);
    chk("b2b_span", 34'(last_cyc - first_cyc), 34'd23);
    chk_cnt(1, 3, 0, 0);

    // backpressure: third packet finds the buffer full
    @(posedge clk); #1 m_tready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b0, 32'hA5BE3000 + 32'(p), 32'h0, 4, 3, -1, (p < 2), 1'b0);
      repeat (3) @(posedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      chk("stall_tvalid", 34'(m_tvalid), 34'd1);
    end
    chk_cnt(1, 3, 1, 0);
    @(posedge clk); #1 m_tready = 1'b1;
    wait_drain();
    chk_cnt(1, 3, 1, 0);

    // reset during output beat 2
    sb_off = 1'b1;
    drive(1'b1, 1'b0, 32'hA5BE4000, 32'h0, 4, 3, -1, 1'b0, 1'b0);
    for (i = 0; i < 50 && !(m_tvalid && m_tready); i++) @(negedge clk);
    chk("rst_beat1_seen", 34'(m_tvalid), 34'd1);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 34'(m_tvalid), 34'd0);
    chk("midrst_tdata", 34'(m_tdata), 34'd0);
    @(posedge clk); #1 resetn = 1'b1;
    sb.delete();
    sb_off = 1'b0;
    repeat (2) @(posedge clk);
    drive(1'b1, 1'b0, 32'hA5BE5000, 32'h0, 4, 3, -1, 1'b1, 1'b0);
    wait_drain();
    chk_cnt(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
